// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI mode-0 responder: STAT bit positions and the idle TX byte.
package spi_slave_pkg;
  localparam int RXV = 0;
  localparam int TXE = 1;
  localparam int OVR = 2;
  localparam int UNR = 3;
  localparam int ABT = 4;
  localparam int SEL = 5;

  localparam logic [7:0] FILL_DEF = 8'hFF;
endpackage

// File: rtl/spi_slave_io_if.sv
// j1 IO bus as seen by one peripheral; io_din must be zero when not addressed.
interface spi_slave_io_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;

  modport master (output io_rd, io_wr, mem_addr, dout, input io_din);
  modport slave  (input io_rd, io_wr, mem_addr, dout, output io_din);
endinterface

// File: rtl/spi_slave_io_sync_edge.sv
// N-stage synchronizer with one delay flop; rise/fall decode from flopped values only.
module sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{INIT}};
      dly  <= INIT;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      dly  <= sync[STAGES-1];
    end
  end

  assign s    = sync[STAGES-1];
  assign rise = s & ~dly;
  assign fall = ~s & dly;
endmodule

// File: rtl/spi_slave_io.sv
// SPI mode-0 target on the j1 IO bus; every SPI pin is oversampled in the clk domain.
module spi_slave_io
  import spi_slave_pkg::*;
#(
  parameter logic [15:0] ADDR_DATA   = 16'h0400,
  parameter logic [15:0] ADDR_STAT   = 16'h0401,
  parameter logic [7:0]  FILL        = FILL_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_io_if.slave  bus,
  input  logic           spi_sck,
  input  logic           spi_ssb,
  input  logic           spi_si,
  output logic           spi_so,
  output logic           spi_so_oe,
  output logic           irq
);
  logic sck_s, sck_rise, sck_fall;
  logic ssb_s, ssb_rise, ssb_fall;
  logic [SYNC_STAGES-1:0] si_sync;
  logic si_s;

  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d(spi_sck), .s(sck_s), .rise(sck_rise), .fall(sck_fall));
  sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ssb (
    .clk(clk), .reset(reset), .d(spi_ssb), .s(ssb_s), .rise(ssb_rise), .fall(ssb_fall));

  always_ff @(posedge clk) begin
    if (reset) si_sync <= '0;
    else       si_sync <= {si_sync[SYNC_STAGES-2:0], spi_si};
  end
  assign si_s = si_sync[SYNC_STAGES-1];

  logic sel, sel_start, sel_end, bit_rise, bit_fall;
  assign sel       = ~ssb_s;
  assign sel_start = ssb_fall;
  assign sel_end   = ssb_rise;
  assign bit_rise  = sck_rise & sel;
  assign bit_fall  = sck_fall & sel;

  logic rd_data, wr_data, wr_stat;
  assign rd_data = bus.io_rd & (bus.mem_addr == ADDR_DATA);
  assign wr_data = bus.io_wr & (bus.mem_addr == ADDR_DATA);
  assign wr_stat = bus.io_wr & (bus.mem_addr == ADDR_STAT);

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, rx_buf, tx_shift, tx_buf;
  logic       rx_valid, tx_full, ovr, unr, abt;
  logic       tx_load;
  logic [7:0] rx_next;

  assign tx_load = sel_start | (bit_fall & (bit_cnt == 3'd0));
  assign rx_next = {rx_shift[6:0], si_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_buf    <= '0;
      tx_shift  <= '0;
      tx_buf    <= '0;
      rx_valid  <= 1'b0;
      tx_full   <= 1'b0;
      ovr       <= 1'b0;
      unr       <= 1'b0;
      abt       <= 1'b0;
      spi_so    <= 1'b1;
      spi_so_oe <= 1'b0;
    end else begin
      spi_so_oe <= sel;
      // Clears come first so a same-cycle set below overrides them.
      if (rd_data) rx_valid <= 1'b0;
      if (wr_stat) begin
        if (bus.dout[OVR]) ovr <= 1'b0;
        if (bus.dout[UNR]) unr <= 1'b0;
        if (bus.dout[ABT]) abt <= 1'b0;
      end

      if (tx_load) begin
        if (tx_full) begin
          tx_shift <= tx_buf;
          spi_so   <= tx_buf[7];
          tx_full  <= 1'b0;
        end else begin
          tx_shift <= FILL;
          spi_so   <= FILL[7];
          unr      <= 1'b1;
        end
      end else if (bit_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        spi_so   <= tx_shift[6];
      end
      // A CPU write landing with a load keeps its byte for the next boundary.
      if (wr_data) begin
        tx_buf  <= bus.dout[7:0];
        tx_full <= 1'b1;
      end

      if (sel_start) bit_cnt <= '0;
      if (bit_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_buf   <= rx_next;
          rx_valid <= 1'b1;
          if (rx_valid && !rd_data) ovr <= 1'b1;
        end
      end

      if (sel_end) begin
        spi_so <= 1'b1;
        if (bit_cnt != 3'd0) begin
          abt      <= 1'b1;
          bit_cnt  <= '0;
          rx_shift <= '0;
        end
      end
    end
  end

  assign irq = rx_valid;

  always_comb begin
    bus.io_din = 16'd0;
    if (bus.mem_addr == ADDR_DATA)
      bus.io_din = {8'd0, rx_buf};
    else if (bus.mem_addr == ADDR_STAT)
      bus.io_din = {10'd0, sel, abt, unr, ovr, ~tx_full, rx_valid};
  end

  logic unused_dout;
  assign unused_dout = &{1'b0, bus.dout[15:8]};
endmodule

// File: tb/tb_spi_slave_io.sv
// Bench for spi_slave_io: a bit-level SPI host at SCK=clk/8 plus CPU bus tasks and a scoreboard.
module tb_spi_slave_io;
  localparam logic [15:0] A_DATA = 16'h0400;
  localparam logic [15:0] A_STAT = 16'h0401;

  logic clk = 1'b0;
  logic reset;
  logic spi_sck, spi_ssb, spi_si, spi_so, spi_so_oe, irq;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0]  exp_miso[$];
  logic [7:0]  exp_rx[$];
  logic [15:0] rd_snap;

  spi_slave_io_if bus();

  spi_slave_io #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .spi_sck(spi_sck), .spi_ssb(spi_ssb), .spi_si(spi_si),
    .spi_so(spi_so), .spi_so_oe(spi_so_oe), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Any unmapped address must read as zero, whatever the block is doing.
  always @(posedge clk)
    if (!reset && bus.mem_addr != A_DATA && bus.mem_addr != A_STAT)
      assert (bus.io_din == 16'd0) else chk("io_din_unmapped", bus.io_din, 16'd0);

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.mem_addr = a; bus.dout = d; bus.io_wr = 1'b1;
    @(negedge clk);
    bus.io_wr = 1'b0; bus.mem_addr = 16'h0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.mem_addr = a; bus.io_rd = 1'b1;
    #1 d = bus.io_din;
    @(negedge clk);
    bus.io_rd = 1'b0; bus.mem_addr = 16'h0;
  endtask

  task automatic stat_chk(input string tag, input logic [15:0] exp);
    logic [15:0] d;
    cpu_rd(A_STAT, d);
    chk(tag, d, exp);
  endtask

  // rx_buf keeps only the newest byte, so the expectation is the last one pushed.
  task automatic data_chk(input string tag);
    logic [15:0] d, e;
    e = {8'd0, exp_rx[$]};
    exp_rx.delete();
    cpu_rd(A_DATA, d);
    chk(tag, d, e);
  endtask

  task automatic ssb_lo();
    @(negedge clk); spi_ssb = 1'b0;
    cyc(8);
  endtask

  task automatic ssb_hi();
    @(negedge clk); spi_ssb = 1'b1;
    cyc(4); spi_sck = 1'b0;
    cyc(4);
  endtask

  // One byte (or nbits of it) MSB first; with last set SCK stays high so SSB rises before the idle fall.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input bit last,
                      input bit lat, input bit rd, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_si = mosi[7-i];
      cyc(4);
      miso = {miso[6:0], spi_so};
      spi_sck = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (i == 7) begin
          if (lat && k == 2) chk("rxv_before_lat", {15'd0, irq}, 16'd0);
          if (lat && k == 3) chk("rxv_at_lat", {15'd0, irq}, 16'd1);
          if (rd && k == 2) begin
            bus.mem_addr = A_DATA; bus.io_rd = 1'b1;
            #1 rd_snap = bus.io_din;
          end
          if (rd && k == 3) begin bus.io_rd = 1'b0; bus.mem_addr = 16'h0; end
        end
      end
      if (!(last && i == nbits - 1)) spi_sck = 1'b0;
    end
  endtask

  task automatic host_byte(input logic [7:0] mosi, input logic [7:0] so_exp,
                           input bit last, input bit lat, input bit rd);
    logic [7:0] m, e;
    exp_miso.push_back(so_exp);
    exp_rx.push_back(mosi);
    xfer(mosi, 8, last, lat, rd, m);
    e = exp_miso.pop_front();
    chk("miso", {8'd0, m}, {8'd0, e});
  endtask

  initial begin
    logic [7:0]  m;
    logic [15:0] d;
    reset = 1'b1; spi_sck = 1'b0; spi_ssb = 1'b1; spi_si = 1'b0;
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.mem_addr = 16'h0; bus.dout = 16'h0;
    rd_snap = 16'h0;
    cyc(4); reset = 1'b0; cyc(2);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_so", {15'd0, spi_so}, 16'd1);
    chk("rst_oe", {15'd0, spi_so_oe}, 16'd0);
    stat_chk("rst_stat", 16'h0002);

    // A5 from the host, nothing queued for TX: FILL goes out, underrun set
    ssb_lo();
    chk("oe_in_frame", {15'd0, spi_so_oe}, 16'd1);
    host_byte(8'hA5, 8'hFF, 1'b1, 1'b1, 1'b0);
    ssb_hi();
    chk("so_idle", {15'd0, spi_so}, 16'd1);
    chk("oe_idle", {15'd0, spi_so_oe}, 16'd0);
    stat_chk("t1_stat", 16'h000B);
    data_chk("t1_data");
    stat_chk("t1_stat_rd", 16'h000A);
    cpu_wr(A_STAT, 16'h001C);
    stat_chk("t1_clr", 16'h0002);

    // queued TX byte
    cpu_wr(A_DATA, 16'h003C);
    stat_chk("t2_full", 16'h0000);
    ssb_lo();
    host_byte(8'h5C, 8'h3C, 1'b1, 1'b0, 1'b0);
    ssb_hi();
    stat_chk("t2_stat", 16'h0003);
    data_chk("t2_data");

    // two-byte frame, no TX: FF FF, underrun and overrun
    ssb_lo();
    host_byte(8'h81, 8'hFF, 1'b0, 1'b0, 1'b0);
    host_byte(8'h7E, 8'hFF, 1'b1, 1'b0, 1'b0);
    ssb_hi();
    stat_chk("t3_stat", 16'h000F);
    cpu_wr(A_STAT, 16'h0008);
    stat_chk("t3_unr_clr", 16'h0007);
    cpu_wr(A_STAT, 16'h001C);
    data_chk("t3_data");

    // two frames without a read: newest byte wins, overrun
    ssb_lo(); host_byte(8'h11, 8'hFF, 1'b1, 1'b0, 1'b0); ssb_hi();
    ssb_lo(); host_byte(8'h22, 8'hFF, 1'b1, 1'b0, 1'b0); ssb_hi();
    stat_chk("t4_stat", 16'h000F);
    data_chk("t4_data");
    cpu_wr(A_STAT, 16'h001C);
    stat_chk("t4_clr", 16'h0002);

    // abort after 5 bits leaves the held byte alone
    ssb_lo(); host_byte(8'h33, 8'hFF, 1'b1, 1'b0, 1'b0); ssb_hi();
    cpu_wr(A_STAT, 16'h001C);
    ssb_lo(); xfer(8'hC3, 5, 1'b1, 1'b0, 1'b0, m); ssb_hi();
    stat_chk("t5_abort", 16'h001B);
    data_chk("t5_held");
    cpu_wr(A_STAT, 16'h001C);
    ssb_lo(); host_byte(8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0); ssb_hi();
    stat_chk("t5_next_stat", 16'h000B);
    data_chk("t5_next_data");
    cpu_wr(A_STAT, 16'h001C);

    // DATA read lands on the byte-completion edge
    ssb_lo(); host_byte(8'h44, 8'hFF, 1'b1, 1'b0, 1'b0); ssb_hi();
    cpu_wr(A_STAT, 16'h001C);
    ssb_lo(); host_byte(8'h99, 8'hFF, 1'b1, 1'b0, 1'b1); ssb_hi();
    chk("t6_old_byte", rd_snap, 16'h0044);
    stat_chk("t6_stat", 16'h000B);
    data_chk("t6_data");
    cpu_wr(A_STAT, 16'h001C);

    // reset in the middle of a frame
    cpu_wr(A_DATA, 16'h00C7);
    ssb_lo(); xfer(8'hF0, 3, 1'b0, 1'b0, 1'b0, m);
    reset = 1'b1; cyc(2); reset = 1'b0;
    chk("mid_rst_so", {15'd0, spi_so}, 16'd1);
    chk("mid_rst_oe", {15'd0, spi_so_oe}, 16'd0);
    chk("mid_rst_irq", {15'd0, irq}, 16'd0);
    stat_chk("mid_rst_stat", 16'h0002);
    ssb_hi();
    cpu_wr(A_STAT, 16'h001C);
    stat_chk("mid_rst_after", 16'h0002);

    // unmapped addresses read as zero, with flags and data non-zero
    ssb_lo(); host_byte(8'hE1, 8'hFF, 1'b1, 1'b0, 1'b0); ssb_hi();
    foreach (exp_rx[i]) ;
    begin
      logic [15:0] addrs [6];
      addrs = '{16'h0000, 16'h03FF, 16'h0402, 16'h0500, 16'h1400, 16'hFFFF};
      foreach (addrs[i]) begin
        cpu_rd(addrs[i], d);
        chk("unmapped_rd", d, 16'h0000);
      end
    end
    data_chk("final_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
